// File: rtl/m_btb_predictor.sv
// Fully-associative branch target buffer: same-cycle lookup for IF, resolved-branch
// update from ID with 2-bit hysteresis, invalid-first / round-robin replacement.
module m_btb_entry #(
  parameter int AW = 11
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic          flush,
  input  logic          alloc,
  input  logic          upd,
  input  logic          btaken,
  input  logic [AW-1:0] baddr,
  input  logic [AW-1:0] btgt,
  input  logic [AW-1:0] paddr,
  output logic          lmatch,
  output logic          bmatch,
  output logic          vld,
  output logic [AW-1:0] tgt,
  output logic [1:0]    ctr
);
  logic [AW-1:0] tag;

  assign lmatch = vld && (tag == paddr);
  assign bmatch = vld && (tag == baddr);

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      vld <= 1'b0;
      tag <= '0;
      tgt <= '0;
      ctr <= 2'd0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (alloc) begin
      vld <= 1'b1;
      tag <= baddr;
      tgt <= btgt;
      ctr <= 2'd2;
    end else if (upd) begin
      if (btaken) begin
        ctr <= (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        tgt <= btgt;
      end else begin
        ctr <= (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
      end
    end
  end
endmodule

module m_btb_predictor #(
  parameter int AW    = 11,
  parameter int DEPTH = 4,
  parameter int CW    = 32
) (
  input  logic          w_clk,
  input  logic          w_rst,
  input  logic [AW-1:0] w_paddr,
  output logic          w_pre,
  output logic          w_ptaken,
  output logic [AW-1:0] w_pr,
  input  logic          w_be,
  input  logic [AW-1:0] w_baddr,
  input  logic [AW-1:0] w_btgt,
  input  logic          w_btaken,
  input  logic          w_flush,
  output logic [CW-1:0] r_nupd,
  output logic [CW-1:0] r_nhit
);
  localparam int VW = $clog2(DEPTH);

  logic [DEPTH-1:0]         vld, lmatch, bmatch, hsel, vsel, upd, alloc;
  logic [DEPTH-1:0][AW-1:0] tgt;
  logic [DEPTH-1:0][1:0]    ctr;
  logic [VW-1:0]            r_vp;
  logic                     acc, hit, have_inv;

  assign acc = w_be && !w_flush;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      m_btb_entry #(.AW(AW)) u_ent (
        .w_clk  (w_clk),
        .w_rst  (w_rst),
        .flush  (w_flush),
        .alloc  (alloc[g]),
        .upd    (upd[g]),
        .btaken (w_btaken),
        .baddr  (w_baddr),
        .btgt   (w_btgt),
        .paddr  (w_paddr),
        .lmatch (lmatch[g]),
        .bmatch (bmatch[g]),
        .vld    (vld[g]),
        .tgt    (tgt[g]),
        .ctr    (ctr[g])
      );
    end
  endgenerate

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_pre    = 1'b0;
    w_ptaken = 1'b0;
    w_pr     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (lmatch[i]) begin
        w_pre    = 1'b1;
        w_ptaken = ctr[i][1];
        w_pr     = tgt[i];
      end
    end
  end

  always_comb begin
    hit      = 1'b0;
    hsel     = '0;
    have_inv = 1'b0;
    vsel     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bmatch[i] && !hit) begin
        hit     = 1'b1;
        hsel[i] = 1'b1;
      end
      if (!vld[i] && !have_inv) begin
        have_inv = 1'b1;
        vsel[i]  = 1'b1;
      end
    end
    if (!have_inv) vsel[r_vp] = 1'b1;
    upd   = (acc && hit) ? hsel : '0;
    alloc = (acc && !hit && w_btaken) ? vsel : '0;
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_vp   <= '0;
      r_nupd <= '0;
      r_nhit <= '0;
    end else if (w_flush) begin
      r_vp <= '0;
    end else if (w_be) begin
      r_nupd <= r_nupd + CW'(1);
      if (hit) r_nhit <= r_nhit + CW'(1);
      // Pointer only moves when a live entry is evicted.
      if (!hit && w_btaken && !have_inv) r_vp <= r_vp + VW'(1);
    end
  end
endmodule

// File: tb/tb_m_btb_predictor.sv
// Randomised + directed bench for m_btb_predictor against an array-based table model.
module tb_m_btb_predictor;
  localparam int AW = 11, DEPTH = 4, CW = 4;

  logic          w_clk = 1'b0, w_rst = 1'b1;
  logic [AW-1:0] w_paddr = '0, w_baddr = '0, w_btgt = '0, w_pr;
  logic          w_be = 1'b0, w_btaken = 1'b0, w_flush = 1'b0, w_pre, w_ptaken;
  logic [CW-1:0] r_nupd, r_nhit;

  int n_chk = 0, n_err = 0;

  // Reference table
  bit        m_v[DEPTH];
  int        m_tag[DEPTH], m_tgt[DEPTH], m_ctr[DEPTH];
  int        m_vp, m_nupd, m_nhit;

  m_btb_predictor #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_paddr(w_paddr), .w_pre(w_pre),
    .w_ptaken(w_ptaken), .w_pr(w_pr), .w_be(w_be), .w_baddr(w_baddr),
    .w_btgt(w_btgt), .w_btaken(w_btaken), .w_flush(w_flush),
    .r_nupd(r_nupd), .r_nhit(r_nhit)
  );

  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mfind(input int a);
    for (int i = 0; i < DEPTH; i++)
      if (m_v[i] && m_tag[i] == a) return i;
    return -1;
  endfunction

  task automatic mreset();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_vp = 0; m_nupd = 0; m_nhit = 0;
  endtask

  task automatic mupd(input bit be, input int ba, input int bt, input bit tk, input bit fl);
    int h, vic;
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
      m_vp = 0;
    end else if (be) begin
      m_nupd = (m_nupd + 1) % 16;
      h = mfind(ba);
      if (h >= 0) begin
        m_nhit = (m_nhit + 1) % 16;
        if (tk) begin
          m_ctr[h] = (m_ctr[h] < 3) ? m_ctr[h] + 1 : 3;
          m_tgt[h] = bt;
        end else m_ctr[h] = (m_ctr[h] > 0) ? m_ctr[h] - 1 : 0;
      end else if (tk) begin
        vic = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) vic = i;
        if (vic < 0) begin
          vic = m_vp;
          m_vp = (m_vp + 1) % DEPTH;
        end
        m_v[vic] = 1; m_tag[vic] = ba; m_tgt[vic] = bt; m_ctr[vic] = 2;
      end
    end
  endtask

  task automatic chk_all(input string tag);
    int h;
    h = mfind(int'(w_paddr));
    chk({tag, ".pre"},    32'(w_pre),    32'(h >= 0));
    chk({tag, ".ptaken"}, 32'(w_ptaken), 32'(h >= 0 && m_ctr[h] >= 2));
    chk({tag, ".pr"},     32'(w_pr),     (h >= 0) ? 32'(m_tgt[h]) : 32'd0);
    chk({tag, ".nupd"},   32'(r_nupd),   32'(m_nupd));
    chk({tag, ".nhit"},   32'(r_nhit),   32'(m_nhit));
  endtask

  // Drive one cycle; outputs are checked at the negedge against pre-edge model state.
  task automatic step(input string tag, input bit be, input int ba, input int bt,
                      input bit tk, input bit fl, input int pa);
    w_be = be; w_baddr = AW'(ba); w_btgt = AW'(bt); w_btaken = tk;
    w_flush = fl; w_paddr = AW'(pa);
    @(negedge w_clk);
    chk_all(tag);
    @(posedge w_clk);
    mupd(be, ba, bt, tk, fl);
    #1;
  endtask

  task automatic look(input string tag, input int pa);
    step(tag, 0, 0, 0, 0, 0, pa);
  endtask

  initial begin
    mreset();
    // T1: reset state
    w_paddr = 11'h010;
    #2 chk_all("t1_rst");
    @(negedge w_clk); w_rst = 1'b0;
    @(posedge w_clk); #1;

    // T2: allocate and hysteresis
    step("t2_alloc", 1, 'h010, 'h020, 1, 0, 'h010);
    look("t2_hit", 'h010);
    chk("t2_pr_const", 32'(w_pr), 32'h020);
    step("t2_nt", 1, 'h010, 'h020, 0, 0, 'h010);
    look("t2_after_nt", 'h010);
    step("t2_tk", 1, 'h010, 'h024, 1, 0, 'h010);
    look("t2_after_tk", 'h010);

    // T3: saturation both ways
    repeat (5) step("t3_tk", 1, 'h010, 'h020, 1, 0, 'h010);
    step("t3_nt1", 1, 'h010, 'h020, 0, 0, 'h010);
    step("t3_nt2", 1, 'h010, 'h020, 0, 0, 'h010);
    look("t3_ctr1", 'h010);
    repeat (5) step("t3_nt", 1, 'h010, 'h020, 0, 0, 'h010);
    look("t3_ctr0", 'h010);
    chk("t3_pre_const", 32'(w_pre), 32'd1);

    // T4: replacement with a full table
    step("t4_flush", 0, 0, 0, 0, 1, 'h010);
    for (int i = 0; i < 6; i++) step("t4_alloc", 1, 'h100 + i, 'h300 + i, 1, 0, 'h100 + i);
    for (int i = 0; i < 6; i++) look("t4_look", 'h100 + i);
    step("t4_nt_miss", 1, 'h1f0, 'h3f0, 0, 0, 'h1f0);
    for (int i = 0; i < 6; i++) look("t4_look2", 'h100 + i);

    // T5: flush beats update; same-cycle lookup/update
    step("t5_flush_be", 1, 'h030, 'h040, 1, 1, 'h102);
    look("t5_after_flush", 'h030);
    step("t5_same", 1, 'h030, 'h040, 1, 0, 'h030);
    look("t5_next", 'h030);

    // Randomised traffic over a small address pool (also wraps CW=4 stats)
    for (int n = 0; n < 400; n++) begin
      step("rnd", $urandom_range(99) < 70, 'h200 + $urandom_range(7), $urandom_range(2047),
           $urandom_range(99) < 60, $urandom_range(99) < 3, 'h200 + $urandom_range(7));
    end

    // T6: async reset between edges during an update burst
    for (int i = 0; i < 3; i++) step("t6_burst", 1, 'h200 + i, 'h400 + i, 1, 0, 'h200);
    w_be = 1'b1; w_baddr = 11'h201; w_btgt = 11'h555; w_btaken = 1'b1; w_paddr = 11'h200;
    #2 w_rst = 1'b1;
    mreset();
    #1 chk_all("t6_async");
    @(posedge w_clk); #1 chk_all("t6_held");
    @(negedge w_clk); w_rst = 1'b0; w_be = 1'b0;
    @(posedge w_clk); #1;
    look("t6_empty", 'h200);
    look("t6_empty2", 'h201);
    for (int i = 0; i < 17; i++) step("t6_wrap", 1, 'h600, 'h601, 1, 0, 'h600);
    look("t6_wrapped", 'h600);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "timeout");
  end
endmodule
